// File: rtl/tube_pkg.sv
// -----------------------------------------------------------------------------
// tube_pkg
// Shared constants for the seven-segment tube scan controller:
//   - SEG_HEX    : active-low segment patterns for hex digits 0..F
//                  (a..g = bits 0..6, dp = bit 7, dp always off)
//   - SEG_BLANK  : all segments off
//   - ADDR_*     : register select values on the bus 'addr' line
//   - CTRL_*     : bit positions, write mask and reset value of CTRL
//   - onehot4()  : digit index to one-hot select helper
// -----------------------------------------------------------------------------
package tube_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index n gives the pattern for hex digit n. A lit segment is a 0.
    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'hC0,  // 0
        8'hF9,  // 1
        8'hA4,  // 2
        8'hB0,  // 3
        8'h99,  // 4
        8'h92,  // 5
        8'h82,  // 6
        8'hF8,  // 7
        8'h80,  // 8
        8'h90,  // 9
        8'h88,  // A
        8'h83,  // B
        8'hC6,  // C
        8'hA1,  // D
        8'h86,  // E
        8'h8E   // F
    };

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_LZB       = 1;
    localparam int CTRL_T2EN      = 3;
    localparam int CTRL_T2VAL_LSB = 4;

    // Only bits 0, 1, 3 and 7:4 exist; bit 2 and bits 31:8 read as 0.
    localparam logic [7:0] CTRL_MASK  = 8'hFB;
    localparam logic [7:0] CTRL_RESET = 8'h01;

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/tube_decoder.sv
// -----------------------------------------------------------------------------
// tube_decoder
// Combinational hex nibble to seven-segment pattern (active low).
// Ports:
//   nibble [3:0]  in   hex value to display
//   blank         in   1 = force all segments off
//   seg    [7:0]  out  segment pattern, a..g = bits 0..6, dp = bit 7 (off)
// -----------------------------------------------------------------------------
module tube_decoder
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = SEG_HEX[nibble];
        end
    end

endmodule

// File: rtl/tube_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tube_scan_ctrl
// Memory-mapped scan controller for three seven-segment tube groups.
// The CPU writes a 32-bit DATA word (eight hex nibbles) and a CTRL word.
// Nibbles d0..d3 are multiplexed onto group 0, d4..d7 onto group 1, both
// sharing one digit index. Group 2 is a single mode digit.
//
// Ports:
//   clk                     in   system clock
//   reset                   in   synchronous active-high reset
//   we                      in   bus write strobe
//   addr                    in   0 = DATA, 1 = CTRL
//   byteen [3:0]            in   write byte enables
//   wdata  [31:0]           in   write data
//   rdata  [31:0]           out  combinational read of the selected register
//   digital_tube0 [7:0]     out  low group segments (active low)
//   digital_tube_sel0 [3:0] out  low group digit select (one-hot, active high)
//   digital_tube1 [7:0]     out  high group segments
//   digital_tube_sel1 [3:0] out  high group digit select
//   digital_tube2 [7:0]     out  mode digit segments
//   digital_tube_sel2       out  mode digit select
//
// CTRL: bit0 en, bit1 lzb (leading-zero blank), bit3 t2en, bits 7:4 t2val.
// All tube outputs are registered from the current register/scan state, so a
// register write shows up on the pins one edge after it lands.
// -----------------------------------------------------------------------------
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int SCAN_DIV = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Bus registers
    // ------------------------------------------------------------------
    logic [31:0] data_reg, data_next;
    logic [7:0]  ctrl_reg, ctrl_next;

    always_comb begin
        data_next = data_reg;
        ctrl_next = ctrl_reg;
        if (we && (addr == ADDR_DATA)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteen[b]) begin
                    data_next[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        // Every CTRL field lives in byte 0, so the upper enables are ignored.
        if (we && (addr == ADDR_CTRL) && byteen[0]) begin
            ctrl_next = wdata[7:0] & CTRL_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
            ctrl_reg <= CTRL_RESET;
        end else begin
            data_reg <= data_next;
            ctrl_reg <= ctrl_next;
        end
    end

    always_comb begin
        rdata = data_reg;
        if (addr == ADDR_CTRL) begin
            rdata = {24'h0, ctrl_reg};
        end
    end

    logic       en;
    logic       lzb;
    logic       t2en;
    logic [3:0] t2val;

    assign en    = ctrl_reg[CTRL_EN];
    assign lzb   = ctrl_reg[CTRL_LZB];
    assign t2en  = ctrl_reg[CTRL_T2EN];
    assign t2val = ctrl_reg[CTRL_T2VAL_LSB +: 4];

    // ------------------------------------------------------------------
    // Scan divider and digit index
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (!en) begin
            // Held at zero so that re-enabling restarts from digit 0.
            cnt_next = '0;
            idx_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = idx_reg + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Nibble split and leading-zero detect
    // A digit is blanked when lzb is set and it and every digit above it
    // are zero. d0 is never blanked so an all-zero value still shows "0".
    // ------------------------------------------------------------------
    logic [3:0] nib [0:7];
    logic [7:0] nz;
    logic [7:0] lz_blank;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign nib[gi] = data_reg[4*gi +: 4];
            assign nz[gi]  = |data_reg[4*gi +: 4];
            if (gi == 0) begin : g_d0
                assign lz_blank[gi] = 1'b0;
            end else begin : g_dn
                assign lz_blank[gi] = lzb & ~(|nz[7:gi]);
            end
        end
    endgenerate

    logic [2:0] pos_lo;
    logic [2:0] pos_hi;

    assign pos_lo = {1'b0, idx_reg};
    assign pos_hi = {1'b1, idx_reg};

    logic [3:0] nib_lo, nib_hi;
    logic       blank_lo, blank_hi;

    assign nib_lo   = nib[pos_lo];
    assign nib_hi   = nib[pos_hi];
    assign blank_lo = lz_blank[pos_lo];
    assign blank_hi = lz_blank[pos_hi];

    // ------------------------------------------------------------------
    // Segment decoders, one per group
    // ------------------------------------------------------------------
    logic [7:0] seg_lo, seg_hi, seg_mode;

    tube_decoder u_dec_lo (
        .nibble (nib_lo),
        .blank  (blank_lo),
        .seg    (seg_lo)
    );

    tube_decoder u_dec_hi (
        .nibble (nib_hi),
        .blank  (blank_hi),
        .seg    (seg_hi)
    );

    tube_decoder u_dec_mode (
        .nibble (t2val),
        .blank  (~t2en),
        .seg    (seg_mode)
    );

    // ------------------------------------------------------------------
    // Output registers
    // Select and segments are computed from the same idx_reg in the same
    // cycle, so they always change together.
    // ------------------------------------------------------------------
    logic [7:0] tube0_reg, tube0_next;
    logic [3:0] sel0_reg,  sel0_next;
    logic [7:0] tube1_reg, tube1_next;
    logic [3:0] sel1_reg,  sel1_next;
    logic [7:0] tube2_reg, tube2_next;
    logic       sel2_reg,  sel2_next;

    always_comb begin
        tube0_next = SEG_BLANK;
        sel0_next  = 4'b0000;
        tube1_next = SEG_BLANK;
        sel1_next  = 4'b0000;
        tube2_next = SEG_BLANK;
        sel2_next  = 1'b0;
        if (en) begin
            tube0_next = seg_lo;
            sel0_next  = onehot4(idx_reg);
            tube1_next = seg_hi;
            sel1_next  = onehot4(idx_reg);
            tube2_next = seg_mode;
            sel2_next  = t2en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tube0_reg <= SEG_BLANK;
            sel0_reg  <= 4'b0000;
            tube1_reg <= SEG_BLANK;
            sel1_reg  <= 4'b0000;
            tube2_reg <= SEG_BLANK;
            sel2_reg  <= 1'b0;
        end else begin
            tube0_reg <= tube0_next;
            sel0_reg  <= sel0_next;
            tube1_reg <= tube1_next;
            sel1_reg  <= sel1_next;
            tube2_reg <= tube2_next;
            sel2_reg  <= sel2_next;
        end
    end

    assign digital_tube0     = tube0_reg;
    assign digital_tube_sel0 = sel0_reg;
    assign digital_tube1     = tube1_reg;
    assign digital_tube_sel1 = sel1_reg;
    assign digital_tube2     = tube2_reg;
    assign digital_tube_sel2 = sel2_reg;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tube_scan_ctrl
// Directed self-checking bench for tube_scan_ctrl with SCAN_DIV = 4.
// -----------------------------------------------------------------------------
module tb_tube_scan_ctrl;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        we     = 1'b0;
    logic        addr   = 1'b0;
    logic [3:0]  byteen = 4'h0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  tube0;
    logic [3:0]  sel0;
    logic [7:0]  tube1;
    logic [3:0]  sel1;
    logic [7:0]  tube2;
    logic        sel2;

    int tests = 0;
    int fails = 0;

    tube_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .we                (we),
        .addr              (addr),
        .byteen            (byteen),
        .wdata             (wdata),
        .rdata             (rdata),
        .digital_tube0     (tube0),
        .digital_tube_sel0 (sel0),
        .digital_tube1     (tube1),
        .digital_tube_sel1 (sel1),
        .digital_tube2     (tube2),
        .digital_tube_sel2 (sel2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a, input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        byteen = be;
        wdata  = d;
        we     = 1'b1;
        step();
        we     = 1'b0;
        byteen = 4'h0;
        $display("[TB] write addr=%0d byteen=%b data=%08h", a, be, d);
    endtask

    task automatic wait_sel0(input logic [3:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (sel0 === s) ok = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] exp_sel;
        reset = 1'b1;
        we    = 1'b0;
        repeat (2) step();
        tests++; if (tube0 !== 8'hFF) begin fails++; $display("FAIL reset_tube0 got=%h exp=ff", tube0); end
        tests++; if (tube1 !== 8'hFF) begin fails++; $display("FAIL reset_tube1 got=%h exp=ff", tube1); end
        tests++; if (tube2 !== 8'hFF) begin fails++; $display("FAIL reset_tube2 got=%h exp=ff", tube2); end
        tests++; if (sel0 !== 4'h0) begin fails++; $display("FAIL reset_sel0 got=%b exp=0000", sel0); end
        tests++; if (sel1 !== 4'h0) begin fails++; $display("FAIL reset_sel1 got=%b exp=0000", sel1); end
        tests++; if (sel2 !== 1'b0) begin fails++; $display("FAIL reset_sel2 got=%b exp=0", sel2); end
        addr = 1'b1; #1;
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL reset_ctrl got=%h exp=00000001", rdata); end
        addr = 1'b0; #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=00000000", rdata); end
        reset = 1'b0;
        // Edge 1 after the last reset edge shows digit 0; each digit held 4 edges.
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_sel = 4'b0001 << (((k - 1) / 4) % 4);
            tests++;
            if (sel0 !== exp_sel) begin
                fails++;
                $display("FAIL reset_scan k=%0d sel0 got=%b exp=%b", k, sel0, exp_sel);
            end
        end
        $display("[TB] test_reset done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_display();
        logic [7:0] e0 [4] = '{8'hC0, 8'h83, 8'hF9, 8'hC0};
        logic [3:0] s;
        bit ok;
        bus_write(1'b1, 4'hF, 32'h0000_0001);
        bus_write(1'b0, 4'hF, 32'h0000_01B0);
        for (int i = 0; i < 4; i++) begin
            s = 4'b0001 << i;
            wait_sel0(s, ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL basic_timeout idx=%0d sel0 got=%b exp=%b", i, sel0, s);
            end else begin
                tests++; if (tube0 !== e0[i]) begin fails++; $display("FAIL basic_tube0 idx=%0d got=%h exp=%h", i, tube0, e0[i]); end
                tests++; if (tube1 !== 8'hC0) begin fails++; $display("FAIL basic_tube1 idx=%0d got=%h exp=c0", i, tube1); end
                tests++; if (sel1 !== s) begin fails++; $display("FAIL basic_sel1 idx=%0d got=%b exp=%b", i, sel1, s); end
                tests++; if (tube2 !== 8'hFF || sel2 !== 1'b0) begin fails++; $display("FAIL basic_mode idx=%0d got=%h/%b exp=ff/0", i, tube2, sel2); end
            end
        end
        $display("[TB] test_basic_display done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_lzb();
        logic [7:0] e0 [4] = '{8'hC0, 8'h83, 8'hF9, 8'hFF};
        logic [7:0] z0 [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        logic [3:0] s;
        bit ok;
        bus_write(1'b1, 4'hF, 32'h0000_0003);
        addr = 1'b1; #1;
        tests++; if (rdata !== 32'h3) begin fails++; $display("FAIL lzb_ctrl_read got=%h exp=00000003", rdata); end
        for (int i = 0; i < 4; i++) begin
            s = 4'b0001 << i;
            wait_sel0(s, ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL lzb_timeout idx=%0d sel0 got=%b exp=%b", i, sel0, s);
            end else begin
                tests++; if (tube0 !== e0[i]) begin fails++; $display("FAIL lzb_tube0 idx=%0d got=%h exp=%h", i, tube0, e0[i]); end
                tests++; if (tube1 !== 8'hFF) begin fails++; $display("FAIL lzb_tube1 idx=%0d got=%h exp=ff", i, tube1); end
            end
        end
        bus_write(1'b0, 4'hF, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            s = 4'b0001 << i;
            wait_sel0(s, ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL lzb0_timeout idx=%0d sel0 got=%b exp=%b", i, sel0, s);
            end else begin
                tests++; if (tube0 !== z0[i]) begin fails++; $display("FAIL lzb0_tube0 idx=%0d got=%h exp=%h", i, tube0, z0[i]); end
                tests++; if (tube1 !== 8'hFF) begin fails++; $display("FAIL lzb0_tube1 idx=%0d got=%h exp=ff", i, tube1); end
            end
        end
        $display("[TB] test_lzb done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_byte_enable();
        bus_write(1'b0, 4'hF, 32'h0000_01B0);
        bus_write(1'b0, 4'b0010, 32'hFFFF_FFFF);
        addr = 1'b0; #1;
        tests++; if (rdata !== 32'h0000_FFB0) begin fails++; $display("FAIL be_data got=%h exp=0000ffb0", rdata); end
        // CTRL currently 3; a write without byte 0 must leave it alone.
        bus_write(1'b1, 4'b1110, 32'h0000_0000);
        addr = 1'b1; #1;
        tests++; if (rdata !== 32'h3) begin fails++; $display("FAIL be_ctrl_hold got=%h exp=00000003", rdata); end
        bus_write(1'b1, 4'hF, 32'hFFFF_FFFF);
        addr = 1'b1; #1;
        tests++; if (rdata !== 32'h0000_00FB) begin fails++; $display("FAIL be_ctrl_unused got=%h exp=000000fb", rdata); end
        bus_write(1'b1, 4'hF, 32'h0000_0001);
        $display("[TB] test_byte_enable done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_mode_disable();
        logic [3:0] exp_sel;
        bus_write(1'b1, 4'hF, 32'h0000_00E9);
        addr = 1'b1; #1;
        tests++; if (rdata !== 32'hE9) begin fails++; $display("FAIL mode_ctrl_read got=%h exp=000000e9", rdata); end
        step();
        tests++; if (tube2 !== 8'h86) begin fails++; $display("FAIL mode_tube2 got=%h exp=86", tube2); end
        tests++; if (sel2 !== 1'b1) begin fails++; $display("FAIL mode_sel2 got=%b exp=1", sel2); end
        bus_write(1'b1, 4'hF, 32'h0000_0000);
        // Output register loaded on the write edge still reflects the old CTRL.
        tests++; if (sel2 !== 1'b1) begin fails++; $display("FAIL dis_lag_sel2 got=%b exp=1", sel2); end
        step();
        tests++; if (tube0 !== 8'hFF || tube1 !== 8'hFF || tube2 !== 8'hFF) begin
            fails++; $display("FAIL dis_segs got=%h/%h/%h exp=ff/ff/ff", tube0, tube1, tube2);
        end
        tests++; if (sel0 !== 4'h0 || sel1 !== 4'h0 || sel2 !== 1'b0) begin
            fails++; $display("FAIL dis_sels got=%b/%b/%b exp=0000/0000/0", sel0, sel1, sel2);
        end
        repeat (5) step();
        tests++; if (sel0 !== 4'h0 || tube0 !== 8'hFF) begin fails++; $display("FAIL dis_hold got=%b/%h exp=0000/ff", sel0, tube0); end
        bus_write(1'b1, 4'hF, 32'h0000_0001);
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_sel = (k <= 4) ? 4'b0001 : 4'b0010;
            tests++;
            if (sel0 !== exp_sel) begin
                fails++; $display("FAIL reen_sel0 k=%0d got=%b exp=%b", k, sel0, exp_sel);
            end
            if (k == 1) begin
                tests++; if (tube0 !== 8'hC0) begin fails++; $display("FAIL reen_tube0 got=%h exp=c0", tube0); end
                tests++; if (tube2 !== 8'hFF || sel2 !== 1'b0) begin fails++; $display("FAIL reen_mode got=%h/%b exp=ff/0", tube2, sel2); end
            end
        end
        $display("[TB] test_mode_disable done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        bit ok;
        bus_write(1'b0, 4'hF, 32'h1234_5678);
        wait_sel0(4'b0100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rmid_timeout sel0 got=%b exp=0100", sel0); end
        reset  = 1'b1;
        we     = 1'b1;
        addr   = 1'b0;
        byteen = 4'hF;
        wdata  = 32'hDEAD_BEEF;
        step();
        we     = 1'b0;
        byteen = 4'h0;
        #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rmid_data got=%h exp=00000000", rdata); end
        tests++; if (tube0 !== 8'hFF || tube1 !== 8'hFF || tube2 !== 8'hFF) begin
            fails++; $display("FAIL rmid_segs got=%h/%h/%h exp=ff/ff/ff", tube0, tube1, tube2);
        end
        tests++; if (sel0 !== 4'h0 || sel1 !== 4'h0 || sel2 !== 1'b0) begin
            fails++; $display("FAIL rmid_sels got=%b/%b/%b exp=0000/0000/0", sel0, sel1, sel2);
        end
        addr = 1'b1; #1;
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL rmid_ctrl got=%h exp=00000001", rdata); end
        reset = 1'b0;
        step();
        tests++; if (sel0 !== 4'b0001) begin fails++; $display("FAIL rmid_restart_sel0 got=%b exp=0001", sel0); end
        tests++; if (tube0 !== 8'hC0 || tube1 !== 8'hC0) begin
            fails++; $display("FAIL rmid_restart_segs got=%h/%h exp=c0/c0", tube0, tube1);
        end
        $display("[TB] test_reset_mid done");
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic_display();
        test_lzb();
        test_byte_enable();
        test_mode_disable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tube_scan_ctrl.md
# tube_scan_ctrl

Memory-mapped scan controller for the board's three seven-segment tube groups. It holds a 32-bit display value and a control word written by the CPU over the peripheral bus. It time-multiplexes the value onto `digital_tube0/1` (four digits each) and drives the single-digit `digital_tube2`. It sits behind the system bridge alongside the switch/key/LED ports, and its outputs go straight to the `fpga_top` tube pins.

## Interface
Parameters:
- `SCAN_DIV`, default 10000: clock cycles each digit position is held; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `we`  in  1  bus write strobe
- `addr`  in  1  register select: 0 = DATA, 1 = CTRL
- `byteen`  in  4  write byte enables; byte i is written when `we && byteen[i]`
- `wdata`  in  32  write data
- `rdata`  out  32  combinational read of the register at `addr`; unused CTRL bits read 0
- `digital_tube0`  out  8  segments of the low group: a..g = bits 0..6, dp = bit 7, active-low
- `digital_tube_sel0`  out  4  digit select of the low group, one-hot, active-high
- `digital_tube1`  out  8  segments of the high group, same encoding as `digital_tube0`
- `digital_tube_sel1`  out  4  digit select of the high group
- `digital_tube2`  out  8  segments of the mode digit
- `digital_tube_sel2`  out  1  select of the mode digit, active-high

## Operation
- DATA[31:0] holds eight hex nibbles, d0 = [3:0] through d7 = [31:28].
- CTRL register:
  - bit0 `en`: enables scanning.
  - bit1 `lzb`: leading-zero blank.
  - bit3 `t2en`: enables the mode digit.
  - bits[7:4] `t2val`: hex value shown on the mode digit.
- Scan state is a divider `cnt`, counting 0..SCAN_DIV-1, and a digit index `idx`, 0..3.
  - When `cnt == SCAN_DIV-1`, `cnt` returns to 0 and `idx` increments, wrapping from 3 to 0.
- Digit mapping for the current `idx`:
  - `digital_tube_sel0` is one-hot at bit `idx` and shows d[idx].
  - `digital_tube_sel1` is one-hot at bit `idx` and shows d[idx+4].
- Leading-zero blanking when `lzb` = 1:
  - Every digit above the highest nonzero nibble shows SEG_BLANK (8'hFF).
  - d0 is never blanked, so DATA = 0 shows a single "0".
- Mode digit: when `t2en` = 1, `digital_tube2` = hex(`t2val`) and `digital_tube_sel2` = 1; otherwise SEG_BLANK and 0.
- Disable: `en` = 0 holds `cnt` and `idx` at 0, drives all segments to 8'hFF and all selects to 0, and forces the mode digit off.
- Decimal points are always off (bit 7 = 1).

## Timing
- Reset values:
  - DATA = 0; CTRL = 32'h0000_0001 (enabled, no blanking, mode digit off).
  - `cnt` = 0, `idx` = 0.
  - All segment outputs 8'hFF; all selects 0; `rdata` follows `addr` combinationally.
- All tube outputs are registered. A DATA/CTRL write at edge N is visible on the segment outputs after edge N+1.
- `idx` advances on the edge where `cnt == SCAN_DIV-1`. Selects change one edge later, together with their segments, so segments and select never mismatch.
- First output after reset release: reset is deasserted before edge 0. Edge 1 drives `sel0 = 4'b0001`, and `idx` becomes 1 at edge SCAN_DIV.
- A write and a scan advance on the same edge are both applied. The next registered output uses the new `idx` with the new DATA.
- A partial write (`byteen` ≠ 4'hF) updates only the enabled bytes. A write to CTRL with `byteen[0]` = 0 leaves `en`, `lzb`, `t2en` and `t2val` unchanged.
- Clearing `en` blanks the outputs on the edge after the write. Re-enabling restarts at `idx` = 0, `cnt` = 0.
- `reset` asserted mid-scan returns every state and output to its reset value at the next edge, regardless of `we`.

## Structure
- Package `tube_pkg` holds:
  - `SEG_HEX[0:15]`, the active-low patterns 0-F (e.g. 0 = 8'hC0, 1 = 8'hF9, B = 8'h83).
  - `SEG_BLANK` = 8'hFF.
  - `ADDR_DATA` = 0, `ADDR_CTRL` = 1.
  - CTRL bit-position constants.
- Sub-module `tube_decoder`: combinational nibble + blank → 8-bit segments. It is instantiated three times, once per group.
- The top holds the registers, divider, index counter, leading-zero detect and output registers.

## Test plan
All scenarios run with SCAN_DIV = 4.
- **Reset:** assert reset for 2 cycles → all segments 8'hFF, selects 0, `rdata` at addr 1 = 32'h1. After release, `sel0` = 0001 → 0010 → 0100 → 1000 → 0001, each held exactly 4 cycles.
- **Basic display:** write DATA = 32'h0000_01B0 (432), `lzb` = 0 → `tube0` shows C0, 83, F9, C0 for idx 0..3; `tube1` shows C0 on all four.
- **Leading-zero blank:** same DATA with CTRL = 32'h3 → `tube0` shows C0, 83, F9, FF; `tube1` shows all FF. Then DATA = 0 → `tube0` idx0 shows C0 and the rest FF.
- **Byte-enable write:** write 32'hFFFF_FFFF to DATA with `byteen` = 4'b0010 over DATA = 32'h1B0 → reads back 32'h0000_FFB0.
- **Mode digit and disable:** write CTRL = 32'h0000_00E9 → `tube2` = 8'h86 ("E"), `sel2` = 1. Then write CTRL = 0 → next edge all FF and selects 0; re-enable resumes at idx 0.
- **Reset mid-operation:** pulse reset during idx 2 with `we` = 1 → DATA reads 0 and outputs return to reset values on the following edge.
